// File: rtl/serial_tx.sv
// Framed parallel-to-serial link transmitter: start bit, then DATA_W bits LSB-first.
// Optional even-parity trailer bit is enabled by defining TX_PARITY_EN.

`ifndef SERIAL_TX_DEFAULT_W
  `define SERIAL_TX_DEFAULT_W 8
`endif

module serial_tx #(
  parameter int DATA_W = `SERIAL_TX_DEFAULT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  output logic              tx_busy,
  input  logic              busy,
  input  logic [DATA_W-1:0] data,
  output logic              serial_out,
  output logic              tx_active
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PEND  = 3'd1,
    S_START = 3'd2,
`ifdef TX_PARITY_EN
    S_DATA  = 3'd3,
    S_PARITY = 3'd4
`else
    S_DATA  = 3'd3
`endif
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               serial_q, serial_d;
  logic               active_q, active_d;
  logic               txbusy_q, txbusy_d;
`ifdef TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      serial_q <= 1'b0;
      active_q <= 1'b0;
      txbusy_q <= 1'b0;
`ifdef TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      serial_q <= serial_d;
      active_q <= active_d;
      txbusy_q <= txbusy_d;
`ifdef TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    serial_d = serial_q;
    active_d = active_q;
    txbusy_d = txbusy_q;
`ifdef TX_PARITY_EN
    parity_d = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (req) begin
          shift_d  = data;
          txbusy_d = 1'b1;
`ifdef TX_PARITY_EN
          parity_d = ^data;
`endif
          if (!busy) begin
            serial_d = 1'b1;
            active_d = 1'b1;
            state_d  = S_START;
          end else begin
            serial_d = 1'b0;
            state_d  = S_PEND;
          end
        end
      end

      S_PEND: begin
        if (!busy) begin
          serial_d = 1'b1;
          active_d = 1'b1;
          state_d  = S_START;
        end
      end

      S_START: begin
        serial_d = shift_q[0];
        shift_d  = shift_q >> 1;
        cnt_d    = CNT_W'(1);
        state_d  = S_DATA;
      end

      S_DATA: begin
        // cnt_q counts bits already put on the line; at DATA_W the last one is showing now.
        if (cnt_q == CNT_W'(DATA_W)) begin
`ifdef TX_PARITY_EN
          serial_d = parity_q;
          state_d  = S_PARITY;
`else
          serial_d = 1'b0;
          active_d = 1'b0;
          txbusy_d = 1'b0;
          cnt_d    = '0;
          state_d  = S_IDLE;
`endif
        end else begin
          serial_d = shift_q[0];
          shift_d  = shift_q >> 1;
          cnt_d    = cnt_q + CNT_W'(1);
        end
      end

`ifdef TX_PARITY_EN
      S_PARITY: begin
        serial_d = 1'b0;
        active_d = 1'b0;
        txbusy_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
`endif

      default: begin
        serial_d = 1'b0;
        active_d = 1'b0;
        txbusy_d = 1'b0;
        cnt_d    = '0;
        state_d  = S_IDLE;
      end
    endcase
  end

  assign serial_out = serial_q;
  assign tx_active  = active_q;
  assign tx_busy    = txbusy_q;

endmodule

// File: tb/tb_serial_tx.sv
// Self-checking bench for serial_tx (DATA_W=8); expected line activity is derived
// from the frame format (start bit, data LSB-first, optional even parity).

module tb_serial_tx;

  localparam int W = 8;
`ifdef TX_PARITY_EN
  localparam int L = 1 + W + 1;
`else
  localparam int L = 1 + W;
`endif

  logic         clk;
  logic         reset;
  logic         req;
  logic         tx_busy;
  logic         busy;
  logic [W-1:0] data;
  logic         serial_out;
  logic         tx_active;

  int checks = 0;
  int errors = 0;

  serial_tx #(.DATA_W(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .tx_busy    (tx_busy),
    .busy       (busy),
    .data       (data),
    .serial_out (serial_out),
    .tx_active  (tx_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference frame: list of line levels while tx_active is high.
  task automatic make_frame(input logic [W-1:0] d, output bit f[$]);
    f = {};
    f.push_back(1'b1);
    for (int i = 0; i < W; i++) f.push_back(d[i]);
`ifdef TX_PARITY_EN
    f.push_back(($countones(d) % 2) == 1);
`endif
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 1'b1; busy = 1'b0; data = 8'h5A;
    #1;
    checks++; if (serial_out !== 1'b0) begin errors++; $display("FAIL reset_serial: got %b want 0", serial_out); end
    checks++; if (tx_busy !== 1'b0) begin errors++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
    checks++; if (tx_active !== 1'b0) begin errors++; $display("FAIL reset_tx_active: got %b want 0", tx_active); end
    repeat (2) @(negedge clk);
    checks++; if ({serial_out, tx_busy, tx_active} !== 3'b000) begin
      errors++; $display("FAIL reset_held_req: got %b want 000", {serial_out, tx_busy, tx_active});
    end
    req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({serial_out, tx_busy, tx_active} !== 3'b000) begin
      errors++; $display("FAIL reset_release_idle: got %b want 000", {serial_out, tx_busy, tx_active});
    end
    $display("reset: outputs low during and after reset");
  endtask

  // One frame with p cycles of back-pressure before the start bit.
  task automatic test_frame(input logic [W-1:0] d, input int p, input bit noisy);
    bit f[$];
    make_frame(d, f);
    @(negedge clk);
    req = 1'b1; data = d; busy = (p > 0);
    for (int i = 0; i < p; i++) begin
      @(negedge clk);
      checks++; if ({serial_out, tx_busy, tx_active} !== 3'b010) begin
        errors++; $display("FAIL pend d=%h cyc%0d: got s/b/a=%b want 010", d, i, {serial_out, tx_busy, tx_active});
      end
      req = noisy ? 1'($urandom) : 1'b0;
      data = W'($urandom);
      busy = (i < p - 1);
    end
    for (int j = 0; j < L; j++) begin
      @(negedge clk);
      checks++; if (serial_out !== f[j]) begin
        errors++; $display("FAIL bit d=%h cyc%0d: serial_out=%b want %b", d, j, serial_out, f[j]);
      end
      checks++; if ({tx_busy, tx_active} !== 2'b11) begin
        errors++; $display("FAIL frame_flags d=%h cyc%0d: busy/active=%b want 11", d, j, {tx_busy, tx_active});
      end
      req = noisy ? 1'($urandom) : 1'b0;
      data = W'($urandom);
      busy = noisy ? 1'($urandom) : 1'b0;
    end
    @(negedge clk);
    checks++; if ({serial_out, tx_busy, tx_active} !== 3'b000) begin
      errors++; $display("FAIL frame_end d=%h: got s/b/a=%b want 000", d, {serial_out, tx_busy, tx_active});
    end
    req = 1'b0; busy = 1'b0;
    $display("frame: data=%h pend=%0d noisy=%0d", d, p, noisy);
  endtask

  task automatic test_back_to_back();
    bit f1[$], f2[$];
    bit es[$], eb[$], ea[$];
    int n;
    make_frame(8'h3C, f1);
    make_frame(8'hFF, f2);
    foreach (f1[i]) begin es.push_back(f1[i]); eb.push_back(1'b1); ea.push_back(1'b1); end
    es.push_back(1'b0); eb.push_back(1'b0); ea.push_back(1'b0);
    foreach (f2[i]) begin es.push_back(f2[i]); eb.push_back(1'b1); ea.push_back(1'b1); end
    es.push_back(1'b0); eb.push_back(1'b0); ea.push_back(1'b0);
    n = es.size();
    @(negedge clk);
    req = 1'b1; data = 8'h3C; busy = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      checks++; if ({serial_out, tx_busy, tx_active} !== {es[k], eb[k], ea[k]}) begin
        errors++; $display("FAIL b2b cyc%0d: got s/b/a=%b want %b%b%b", k,
                           {serial_out, tx_busy, tx_active}, es[k], eb[k], ea[k]);
      end
      if (k == 0) data = 8'hFF;
      req  = (k <= L);
      busy = (k == L || k >= n - 1) ? 1'b0 : 1'($urandom);
    end
    req = 1'b0; busy = 1'b0;
    $display("back_to_back: 3C then FF with held req");
  endtask

  task automatic test_reset_mid_frame();
    bit f[$];
    make_frame(8'hA5, f);
    @(negedge clk);
    req = 1'b1; data = 8'hA5; busy = 1'b0;
    for (int j = 0; j <= 5; j++) begin
      @(negedge clk);
      req = 1'b0;
      checks++; if ({serial_out, tx_active} !== {f[j], 1'b1}) begin
        errors++; $display("FAIL abort_pre cyc%0d: serial/active=%b want %b1", j, {serial_out, tx_active}, f[j]);
      end
    end
    #2 reset = 1'b0;
    #1;
    checks++; if ({serial_out, tx_busy, tx_active} !== 3'b000) begin
      errors++; $display("FAIL abort_async: got s/b/a=%b want 000", {serial_out, tx_busy, tx_active});
    end
    @(negedge clk);
    checks++; if ({serial_out, tx_busy, tx_active} !== 3'b000) begin
      errors++; $display("FAIL abort_hold: got s/b/a=%b want 000", {serial_out, tx_busy, tx_active});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++; if ({serial_out, tx_busy, tx_active} !== 3'b000) begin
      errors++; $display("FAIL abort_idle: got s/b/a=%b want 000", {serial_out, tx_busy, tx_active});
    end
    $display("reset_mid_frame: A5 aborted at data bit 4");
    test_frame(8'h01, 0, 1'b0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 12; n++)
      test_frame(W'($urandom), int'($urandom_range(0, 3)), 1'b1);
  endtask

  initial begin
    reset = 1'b0; req = 1'b0; busy = 1'b0; data = '0;
    test_reset();
    test_frame(8'hA5, 0, 1'b0);
    test_frame(8'h07, 0, 1'b0);
    test_frame(8'hC3, 5, 1'b1);
    test_back_to_back();
    test_reset_mid_frame();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
